qsn_ctrl_len15: RTL

QSN_CTRL_LEN15 -- requirements
Module: qsn_ctrl_len15

---
 rtl/qsn_ctrl_len15_pkg.sv | 26 ++
 rtl/qsn_shift_decode_len15.sv | 23 ++
 rtl/qsn_ctrl_len15.sv | 111 +++++++++++
 3 files changed

// File: rtl/qsn_ctrl_len15_pkg.sv
// Shared constants and control-word types for the 15-lane QSN shift controller.
// Used by qsn_ctrl_len15 (optional range check under QSN_CTRL_RANGE_CHECK_EN).
package qsn_ctrl_len15_pkg;

  localparam int QSN_LEN = 15;
  localparam int SHIFT_W = 4;
  localparam int SEL_W   = QSN_LEN - 1;
  localparam int TAG_MAX = 16;

  typedef struct packed {
    logic [SHIFT_W-1:0] left_shift;
    logic [SHIFT_W-1:0] right_shift;
    logic [SEL_W-1:0]   merge_sel;
  } qsn_map_t;

  // Full control word as seen by the shifter/merge stage; tag sized for the widest TAG_W.
  typedef struct packed {
    logic [SHIFT_W-1:0] left_shift;
    logic [SHIFT_W-1:0] right_shift;
    logic [SEL_W-1:0]   merge_sel;
    logic [TAG_MAX-1:0] tag;
  } ctrl_word_t;

  localparam qsn_map_t MAP_RST = '{left_shift: '0, right_shift: '0, merge_sel: '1};

endpackage

// File: rtl/qsn_shift_decode_len15.sv
// Pure combinational mapping of a cyclic shift factor onto left/right shifter
// amounts and the per-lane merge select.
module qsn_shift_decode_len15
  import qsn_ctrl_len15_pkg::*;
(
  input  logic [SHIFT_W-1:0] shift_i,
  output qsn_map_t           map_o
);

  logic [SEL_W-1:0] sel;

  always_comb begin
    sel = '0;
    for (int i = 0; i < SEL_W; i++) begin
      sel[i] = (i < (QSN_LEN - int'(shift_i)));
    end
  end

  assign map_o.left_shift  = shift_i;
  assign map_o.right_shift = (shift_i == '0) ? '0 : (SHIFT_W'(QSN_LEN) - shift_i);
  assign map_o.merge_sel   = sel;

endmodule

// File: rtl/qsn_ctrl_len15.sv
// QSN shift controller: decodes shift requests and carries them through a
// 1- or 2-stage valid/ready pipeline. Define QSN_CTRL_RANGE_CHECK_EN for the shift_err flag.
module qsn_ctrl_len15
  import qsn_ctrl_len15_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SHIFT_W-1:0] req_shift,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHIFT_W-1:0] left_shift,
  output logic [SHIFT_W-1:0] right_shift,
  output logic [SEL_W-1:0]   merge_sel,
  output logic [TAG_W-1:0]   out_tag
`ifdef QSN_CTRL_RANGE_CHECK_EN
  ,
  output logic               shift_err
`endif
);

  logic               ld1;
  logic [SHIFT_W-1:0] shift_eff;
  qsn_map_t           map_dec;

  logic               s1_valid_q;
  qsn_map_t           s1_map_q;
  logic [TAG_W-1:0]   s1_tag_q;

`ifdef QSN_CTRL_RANGE_CHECK_EN
  logic err_q;
  // A shift of 15 is one full rotation, so fold it to 0 and remember it happened.
  assign shift_eff = (req_shift == SHIFT_W'(QSN_LEN)) ? '0 : req_shift;
  assign shift_err = err_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (req_valid && ld1 && (req_shift == SHIFT_W'(QSN_LEN))) begin
      err_q <= 1'b1;
    end
  end
`else
  assign shift_eff = req_shift;
`endif

  qsn_shift_decode_len15 u_decode (
    .shift_i (shift_eff),
    .map_o   (map_dec)
  );

  assign req_ready = ld1;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_map_q   <= MAP_RST;
      s1_tag_q   <= '0;
    end else if (ld1) begin
      s1_valid_q <= req_valid;
      if (req_valid) begin
        s1_map_q <= map_dec;
        s1_tag_q <= req_tag;
      end
    end
  end

  if (PIPE_DEPTH == 1) begin : g_depth1
    assign ld1         = !s1_valid_q || out_ready;
    assign out_valid   = s1_valid_q;
    assign left_shift  = s1_map_q.left_shift;
    assign right_shift = s1_map_q.right_shift;
    assign merge_sel   = s1_map_q.merge_sel;
    assign out_tag     = s1_tag_q;
  end else begin : g_depth2
    logic             s2_valid_q;
    qsn_map_t         s2_map_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic             ld2;

    assign ld2 = !s2_valid_q || out_ready;
    // Stage 1 frees up whenever stage 2 can take its contents.
    assign ld1 = !s1_valid_q || ld2;

    always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
        s2_valid_q <= 1'b0;
        s2_map_q   <= MAP_RST;
        s2_tag_q   <= '0;
      end else if (ld2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_map_q <= s1_map_q;
          s2_tag_q <= s1_tag_q;
        end
      end
    end

    assign out_valid   = s2_valid_q;
    assign left_shift  = s2_map_q.left_shift;
    assign right_shift = s2_map_q.right_shift;
    assign merge_sel   = s2_map_q.merge_sel;
    assign out_tag     = s2_tag_q;
  end

endmodule
